// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 keyboard definitions: scan-code and ASCII constants,
// the translate-stage entry type and the shifted-digit helper.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] SP = 8'h20;

  typedef enum logic [1:0] {KC_NONE, KC_LETTER, KC_DIGIT, KC_CTRL} key_class_t;

  typedef struct packed {
    logic       hit;
    logic [7:0] ch;
  } key_char_t;

  // US-legend symbols above the digit keys 0..9
  function automatic logic [7:0] shifted_digit(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'h29;
      4'd1:    c = 8'h21;
      4'd2:    c = 8'h40;
      4'd3:    c = 8'h23;
      4'd4:    c = 8'h24;
      4'd5:    c = 8'h25;
      4'd6:    c = 8'h5E;
      4'd7:    c = 8'h26;
      4'd8:    c = 8'h2A;
      4'd9:    c = 8'h28;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scan code to ASCII lookup with shift/caps-lock handling.
// Also used by the LCD stage, so it carries no state.
module ps2_scan2ascii
  import ps2_kbd_pkg::*;
(
  input  logic [7:0] scan,
  input  logic       shift,
  input  logic       capslock,
  output logic [7:0] ascii,
  output logic       hit
);

  key_class_t cls_s;
  logic [4:0] idx_s;
  logic [7:0] ctrl_s;

  // Classify the scan code and find its position within its class
  always_comb begin
    cls_s  = KC_NONE;
    idx_s  = 5'd0;
    ctrl_s = 8'h00;
    case (scan)
      8'h1C: begin cls_s = KC_LETTER; idx_s = 5'd0;  end
      8'h32: begin cls_s = KC_LETTER; idx_s = 5'd1;  end
      8'h21: begin cls_s = KC_LETTER; idx_s = 5'd2;  end
      8'h23: begin cls_s = KC_LETTER; idx_s = 5'd3;  end
      8'h24: begin cls_s = KC_LETTER; idx_s = 5'd4;  end
      8'h2B: begin cls_s = KC_LETTER; idx_s = 5'd5;  end
      8'h34: begin cls_s = KC_LETTER; idx_s = 5'd6;  end
      8'h33: begin cls_s = KC_LETTER; idx_s = 5'd7;  end
      8'h43: begin cls_s = KC_LETTER; idx_s = 5'd8;  end
      8'h3B: begin cls_s = KC_LETTER; idx_s = 5'd9;  end
      8'h42: begin cls_s = KC_LETTER; idx_s = 5'd10; end
      8'h4B: begin cls_s = KC_LETTER; idx_s = 5'd11; end
      8'h3A: begin cls_s = KC_LETTER; idx_s = 5'd12; end
      8'h31: begin cls_s = KC_LETTER; idx_s = 5'd13; end
      8'h44: begin cls_s = KC_LETTER; idx_s = 5'd14; end
      8'h4D: begin cls_s = KC_LETTER; idx_s = 5'd15; end
      8'h15: begin cls_s = KC_LETTER; idx_s = 5'd16; end
      8'h2D: begin cls_s = KC_LETTER; idx_s = 5'd17; end
      8'h1B: begin cls_s = KC_LETTER; idx_s = 5'd18; end
      8'h2C: begin cls_s = KC_LETTER; idx_s = 5'd19; end
      8'h3C: begin cls_s = KC_LETTER; idx_s = 5'd20; end
      8'h2A: begin cls_s = KC_LETTER; idx_s = 5'd21; end
      8'h1D: begin cls_s = KC_LETTER; idx_s = 5'd22; end
      8'h22: begin cls_s = KC_LETTER; idx_s = 5'd23; end
      8'h35: begin cls_s = KC_LETTER; idx_s = 5'd24; end
      8'h1A: begin cls_s = KC_LETTER; idx_s = 5'd25; end
      8'h45: begin cls_s = KC_DIGIT;  idx_s = 5'd0;  end
      8'h16: begin cls_s = KC_DIGIT;  idx_s = 5'd1;  end
      8'h1E: begin cls_s = KC_DIGIT;  idx_s = 5'd2;  end
      8'h26: begin cls_s = KC_DIGIT;  idx_s = 5'd3;  end
      8'h25: begin cls_s = KC_DIGIT;  idx_s = 5'd4;  end
      8'h2E: begin cls_s = KC_DIGIT;  idx_s = 5'd5;  end
      8'h36: begin cls_s = KC_DIGIT;  idx_s = 5'd6;  end
      8'h3D: begin cls_s = KC_DIGIT;  idx_s = 5'd7;  end
      8'h3E: begin cls_s = KC_DIGIT;  idx_s = 5'd8;  end
      8'h46: begin cls_s = KC_DIGIT;  idx_s = 5'd9;  end
      SC_SPACE: begin cls_s = KC_CTRL; ctrl_s = SP; end
      SC_ENTER: begin cls_s = KC_CTRL; ctrl_s = CR; end
      SC_BKSP:  begin cls_s = KC_CTRL; ctrl_s = BS; end
      SC_BREAK: cls_s = KC_NONE;
      default:  cls_s = KC_NONE;
    endcase
  end

  // Caps-lock only affects letters; shift picks the symbol row for digits
  always_comb begin
    ascii = 8'h00;
    hit   = 1'b0;
    case (cls_s)
      KC_LETTER: begin
        ascii = ((shift ^ capslock) ? 8'h41 : 8'h61) + {3'b000, idx_s};
        hit   = 1'b1;
      end
      KC_DIGIT: begin
        ascii = shift ? shifted_digit(idx_s[3:0]) : (8'h30 + {3'b000, idx_s});
        hit   = 1'b1;
      end
      KC_CTRL: begin
        ascii = ctrl_s;
        hit   = 1'b1;
      end
      default: begin
        ascii = 8'h00;
        hit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ps2_key_queue.sv
// Keyboard make codes -> ASCII -> FIFO towards the LCD writer.
// Optional macro TYPEMATIC_FILTER_EN drops auto-repeated make codes.
module ps2_key_queue
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_on,
  input  logic [7:0]    key_value,
  input  logic          relase,
  input  logic          shift,
  input  logic          capslock,
  output logic [7:0]    ascii_data,
  output logic          ascii_valid,
  input  logic          ascii_ready,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam logic [AW:0] FULL_DIFF = {1'b1, {AW{1'b0}}};

  logic [7:0] xl_ascii_s;
  logic       xl_hit_s;
  logic       repeat_s;
  logic       accept_s;
  key_char_t  s1_q, s1_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, level_q, level_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d, ovf_q, ovf_d;
  logic       empty_s, full_s, pop_s, push_s, drop_s;

  ps2_scan2ascii u_xlat (
    .scan     (key_value),
    .shift    (shift),
    .capslock (capslock),
    .ascii    (xl_ascii_s),
    .hit      (xl_hit_s)
  );

`ifdef TYPEMATIC_FILTER_EN
  logic [7:0] last_scan_q, last_scan_d;
  logic       held_q, held_d;

  // A break re-arms the key; any make code becomes the one being held
  always_comb begin
    last_scan_d = last_scan_q;
    held_d      = held_q;
    if (key_on) begin
      if (relase) begin
        held_d = 1'b0;
      end else begin
        last_scan_d = key_value;
        held_d      = 1'b1;
      end
    end else begin
      held_d = held_q;
    end
  end

  // Typematic filter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_scan_q <= 8'h00;
      held_q      <= 1'b0;
    end else begin
      last_scan_q <= last_scan_d;
      held_q      <= held_d;
    end
  end

  assign repeat_s = held_q && (key_value == last_scan_q);
`else
  assign repeat_s = 1'b0;
`endif

  assign accept_s = key_on & ~relase & ~repeat_s;
  assign s1_d.hit = accept_s & xl_hit_s;
  assign s1_d.ch  = xl_ascii_s;

  assign empty_s = (wr_q == rd_q);
  assign full_s  = ((wr_q ^ rd_q) == FULL_DIFF);
  assign pop_s   = ~empty_s & ascii_ready;
  assign push_s  = s1_q.hit & (~full_s | pop_s);
  assign drop_s  = s1_q.hit & full_s & ~pop_s;

  // Next pointers, occupancy and the head entry as seen after this edge
  always_comb begin
    wr_d    = wr_q + {{AW{1'b0}}, push_s};
    rd_d    = rd_q + {{AW{1'b0}}, pop_s};
    valid_d = (wr_d != rd_d);
    level_d = wr_d - rd_d;
    if (push_s && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
      data_d = s1_q.ch;
    end else begin
      data_d = mem_q[rd_d[AW-1:0]];
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Translate stage, pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents are only meaningful between rd and wr
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q[AW-1:0]] <= s1_q.ch;
    end
  end

  assign ascii_data  = data_q;
  assign ascii_valid = valid_q;
  assign level       = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_key_queue.sv
// Directed, scoreboard-based bench for ps2_key_queue.
module tb_ps2_key_queue;

  localparam int DEPTH = 16;
`ifdef TYPEMATIC_FILTER_EN
  localparam int TYPO_N = 2;
`else
  localparam int TYPO_N = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n, key_on, relase, shift, capslock, ascii_ready, clr_ovf;
  logic [7:0] key_value;
  logic [7:0] ascii_data;
  logic       ascii_valid, overflow;
  logic [4:0] level;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

`ifdef TYPEMATIC_FILTER_EN
  bit         held = 1'b0;
  logic [7:0] last_sc = 8'h00;
`endif

  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                8'h3D, 8'h3E, 8'h46};
  string lower_s = "abcdefghijklmnopqrstuvwxyz";
  string upper_s = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
  string digit_s = "0123456789";
  string dshift_s = ")!@#$%^&*(";

  ps2_key_queue #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_on      (key_on),
    .key_value   (key_value),
    .relase      (relase),
    .shift       (shift),
    .capslock    (capslock),
    .ascii_data  (ascii_data),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .level       (level),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [7:0] sc, input logic sh, input logic cp);
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == sc) return {1'b1, (sh ^ cp) ? upper_s[i] : lower_s[i]};
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == sc) return {1'b1, sh ? dshift_s[i] : digit_s[i]};
    if (sc == 8'h29) return {1'b1, 8'h20};
    if (sc == 8'h5A) return {1'b1, 8'h0D};
    if (sc == 8'h66) return {1'b1, 8'h08};
    return 9'h000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] sc, input logic sh, input logic cp,
                       input logic rel, input logic drop);
    logic [8:0] m;
    bit keep;
    m = model(sc, sh, cp);
    keep = 1'b1;
    key_value = sc; shift = sh; capslock = cp; relase = rel; key_on = 1'b1;
    if (rel) begin
`ifdef TYPEMATIC_FILTER_EN
      held = 1'b0;
`endif
    end else begin
`ifdef TYPEMATIC_FILTER_EN
      if (held && sc == last_sc) keep = 1'b0;
      else begin last_sc = sc; held = 1'b1; end
`endif
      if (keep && m[8] && !drop) exp_q.push_back(m[7:0]);
    end
    tick();
    key_on = 1'b0;
    relase = 1'b0;
  endtask

  task automatic drain_one(input string tag);
    logic [7:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, {31'd0, ascii_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, ascii_data}, {24'd0, e});
    ascii_ready = 1'b1;
    tick();
    ascii_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; key_on = 1'b0; relase = 1'b0; shift = 1'b0; capslock = 1'b0;
    ascii_ready = 1'b0; clr_ovf = 1'b0; key_value = 8'h00;
    tick(); tick();
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_valid", {31'd0, ascii_valid}, 32'd0);
    check("rst_data", {24'd0, ascii_data}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Latency: 'a' visible two edges after key_on is sampled
    press(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lat_n1_valid", {31'd0, ascii_valid}, 32'd0);
    tick();
    check("lat_n2_valid", {31'd0, ascii_valid}, 32'd1);
    check("lat_n2_data", {24'd0, ascii_data}, 32'h61);
    check("lat_n2_level", {27'd0, level}, 32'd1);
    drain_one("first");
    check("first_empty", {31'd0, ascii_valid}, 32'd0);

    // Shift/caps cancel, shifted digit, enter; back-to-back pulses
    press(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
    press(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
    press(8'h16, 1'b1, 1'b0, 1'b0, 1'b0);
    press(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("b2b_level", {27'd0, level}, 32'd3);
    while (exp_q.size() > 0) drain_one("b2b");
    check("b2b_level0", {27'd0, level}, 32'd0);

    // Overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) press(letter_sc[i], 1'b0, 1'b0, 1'b0, i == 16);
    tick(); tick();
    check("ovf_level", {27'd0, level}, 32'd16);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr", {31'd0, overflow}, 32'd0);
    check("ovf_clr_level", {27'd0, level}, 32'd16);

    // Full FIFO: push and pop on the same edge
    press(8'h45, 1'b0, 1'b0, 1'b0, 1'b0);
    drain_one("simul");
    check("simul_level", {27'd0, level}, 32'd16);
    check("simul_ovf", {31'd0, overflow}, 32'd0);
    while (exp_q.size() > 0) drain_one("full_drain");
    check("drain_level", {27'd0, level}, 32'd0);
    check("drain_valid", {31'd0, ascii_valid}, 32'd0);

    // Unmapped code and a break event are both ignored
    press(8'h76, 1'b0, 1'b0, 1'b0, 1'b0);
    press(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); tick();
    check("ign_level", {27'd0, level}, 32'd0);
    check("ign_valid", {31'd0, ascii_valid}, 32'd0);

    // Reset while characters are queued and in flight
    press(8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
    press(8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_level", {27'd0, level}, 32'd0);
    check("mid_rst_valid", {31'd0, ascii_valid}, 32'd0);
    exp_q.delete();
`ifdef TYPEMATIC_FILTER_EN
    held = 1'b0;
`endif
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_level", {27'd0, level}, 32'd0);

    // Typematic sequence: make, repeat, break, make
    press(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    press(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    press(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
    press(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("typo_level", {27'd0, level}, TYPO_N);
    while (exp_q.size() > 0) drain_one("typo");
    check("typo_level0", {27'd0, level}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
